uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART Rx path. Consumes the oversampling clock produced by the Rx baud/sampling generator (toggling BaudOut, 8x or 16x baud), detects and validates the start bit, and samples each bit at mid-bit. Shifts in data LSB-first, checks optional parity and the stop bit, then presents the byte with a one-cycle done strobe and error flags. Sits between the sampling generator and the Rx deserialiser/consumer.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_sync_edge.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int OVS8  = 8;
  localparam int OVS16 = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Terminal sample index for a full bit period.
  function automatic logic [3:0] last_sample(input logic ovs16);
    return ovs16 ? 4'(OVS16 - 1) : 4'(OVS8 - 1);
  endfunction

  // Terminal sample index for the start bit, which lands on its middle.
  function automatic logic [3:0] half_sample(input logic ovs16);
    return ovs16 ? 4'(OVS16 / 2 - 1) : 4'(OVS8 / 2 - 1);
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for the serial line and rising-edge tick from the oversample clock.
module uart_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic baud,
  input  logic rx_in,
  output logic rx,
  output logic tick
);

  logic rx_meta;
  logic baud_q;

  // Line idles high, so the synchroniser presets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
      baud_q  <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx      <= rx_meta;
      baud_q  <= baud;
    end
  end

  assign tick = baud & ~baud_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start validation, mid-bit sampling, parity/stop checks, result strobe.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 BaudOut,
  input  logic                 OverSel,
  input  logic                 ParityEn,
  input  logic                 ParityType,
  input  logic                 RxIn,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxDone,
  output logic                 ParityError,
  output logic                 FrameError,
  output logic                 Busy
);

  rx_state_e state, state_nxt;

  logic                 rx, tick;
  logic [3:0]           sample_cnt, bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 cfg_ovs, cfg_pen, cfg_ptype;
  logic                 par_err, stop_rx, fin;
  logic                 start_frame, cnt_clr, cnt_inc, shift_en, par_cap, stop_cap;
  logic [3:0]           last, half;

  uart_sync_edge u_sync (
    .clk   (Clock),
    .rst_n (ResetN),
    .baud  (BaudOut),
    .rx_in (RxIn),
    .rx    (rx),
    .tick  (tick)
  );

  assign last = last_sample(cfg_ovs);
  assign half = half_sample(cfg_ovs);
  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    shift_en    = 1'b0;
    par_cap     = 1'b0;
    stop_cap    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: if (!rx) begin
          state_nxt   = START;
          start_frame = 1'b1;
          cnt_clr     = 1'b1;
        end
        START: if (sample_cnt == half) begin
          cnt_clr   = 1'b1;
          state_nxt = rx ? IDLE : DATA;
        end else cnt_inc = 1'b1;
        DATA: if (sample_cnt == last) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1)) state_nxt = cfg_pen ? PARITY : STOP;
        end else cnt_inc = 1'b1;
        PARITY: if (sample_cnt == last) begin
          cnt_clr   = 1'b1;
          par_cap   = 1'b1;
          state_nxt = STOP;
        end else cnt_inc = 1'b1;
        STOP: if (sample_cnt == last) begin
          cnt_clr   = 1'b1;
          stop_cap  = 1'b1;
          state_nxt = IDLE;
        end else cnt_inc = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters, shift register and latched frame configuration.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cfg_ovs    <= 1'b0;
      cfg_pen    <= 1'b0;
      cfg_ptype  <= PAR_EVEN;
      par_err    <= 1'b0;
      stop_rx    <= 1'b1;
      fin        <= 1'b0;
    end else begin
      if (cnt_clr)      sample_cnt <= '0;
      else if (cnt_inc) sample_cnt <= sample_cnt + 4'd1;
      if (start_frame) begin
        cfg_ovs   <= OverSel;
        cfg_pen   <= ParityEn;
        cfg_ptype <= ParityType;
        bit_cnt   <= '0;
        par_err   <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {rx, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (par_cap) par_err <= (^shreg) ^ rx ^ cfg_ptype;
      if (stop_cap) stop_rx <= rx;
      fin <= stop_cap;
    end
  end

  // Results publish together one cycle after the stop sample and hold until the next frame.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      RxData      <= '0;
      RxDone      <= 1'b0;
      ParityError <= 1'b0;
      FrameError  <= 1'b0;
    end else begin
      RxDone <= fin;
      if (fin) begin
        RxData      <= shreg;
        ParityError <= par_err & cfg_pen;
        FrameError  <= ~stop_rx;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of frames plus glitch, config-toggle and reset sequences.
module tb_uart_rx_ctrl;

  localparam int BHALF = 2;  // clocks per BaudOut half-period

  logic       Clock = 1'b0, ResetN = 1'b0, BaudOut = 1'b0;
  logic       OverSel = 1'b0, ParityEn = 1'b0, ParityType = 1'b0, RxIn = 1'b1;
  logic [7:0] RxData;
  logic       RxDone, ParityError, FrameError, Busy;

  uart_rx_ctrl #(.DATA_BITS(8)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .BaudOut    (BaudOut),
    .OverSel    (OverSel),
    .ParityEn   (ParityEn),
    .ParityType (ParityType),
    .RxIn       (RxIn),
    .RxData     (RxData),
    .RxDone     (RxDone),
    .ParityError(ParityError),
    .FrameError (FrameError),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  int bcnt = 0;
  always @(negedge Clock) begin
    if (bcnt == BHALF - 1) begin
      BaudOut <= ~BaudOut;
      bcnt    <= 0;
    end else bcnt <= bcnt + 1;
  end

  int done_cnt = 0, run = 0, max_run = 0;
  always @(negedge Clock) begin
    if (RxDone) begin
      done_cnt <= done_cnt + 1;
      run      <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else run <= 0;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Clock);
  endtask

  function automatic int bit_clks(input logic ovs16);
    return (ovs16 ? 16 : 8) * 2 * BHALF;
  endfunction

  // Drives one frame at the given oversample rate; a low stop bit is released after 3/4 bit.
  task automatic send_frame(input logic [7:0] d, input logic ovs16, input logic pen,
                            input logic pbit, input logic stop, input int tgl_at);
    int bc;
    bc = bit_clks(ovs16);
    RxIn = 1'b0;
    wait_clk(bc);
    for (int i = 0; i < 8; i++) begin
      if (i == tgl_at) OverSel = ~OverSel;
      RxIn = d[i];
      wait_clk(bc);
    end
    if (pen) begin
      RxIn = pbit;
      wait_clk(bc);
    end
    if (stop) begin
      RxIn = 1'b1;
      wait_clk(bc);
    end else begin
      RxIn = 1'b0;
      wait_clk(bc * 3 / 4);
      RxIn = 1'b1;
      wait_clk(bc / 4);
    end
    wait_clk(2 * bc);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ovs16, pen, ptype, pbit, stop;
    logic [7:0] exp_data;
    logic       exp_perr, exp_ferr;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int d0;
    OverSel    = v.ovs16;
    ParityEn   = v.pen;
    ParityType = v.ptype;
    d0 = done_cnt;
    send_frame(v.data, v.ovs16, v.pen, v.pbit, v.stop, -1);
    chk({tag, " done"},  32'(done_cnt - d0), 32'd1);
    chk({tag, " data"},  32'(RxData), 32'(v.exp_data));
    chk({tag, " perr"},  32'(ParityError), 32'(v.exp_perr));
    chk({tag, " ferr"},  32'(FrameError), 32'(v.exp_ferr));
    chk({tag, " busy"},  32'(Busy), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int d0;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst data", 32'(RxData), 32'd0);
    chk("rst done", 32'(RxDone), 32'd0);
    chk("rst perr", 32'(ParityError), 32'd0);
    chk("rst ferr", 32'(FrameError), 32'd0);
    chk("rst busy", 32'(Busy), 32'd0);
    wait_clk(4);
    ResetN = 1'b1;
    wait_clk(8);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start glitch at 16x: line low for 2 ticks only
    OverSel = 1'b1;
    d0 = done_cnt;
    RxIn = 1'b0;
    wait_clk(2 * 2 * BHALF);
    RxIn = 1'b1;
    wait_clk(2 * bit_clks(1'b1));
    chk("glitch done", 32'(done_cnt - d0), 32'd0);
    chk("glitch data", 32'(RxData), 32'h07);
    chk("glitch perr", 32'(ParityError), 32'd1);
    chk("glitch ferr", 32'(FrameError), 32'd0);
    chk("glitch busy", 32'(Busy), 32'd0);

    // OverSel flipped mid-frame; frame must still decode at 8x
    OverSel  = 1'b0;
    ParityEn = 1'b0;
    wait_clk(4);
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    chk("tgl done", 32'(done_cnt - d0), 32'd1);
    chk("tgl data", 32'(RxData), 32'h55);
    chk("tgl perr", 32'(ParityError), 32'd0);
    chk("tgl ferr", 32'(FrameError), 32'd0);
    chk("tgl busy", 32'(Busy), 32'd0);
    d0 = done_cnt;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    chk("tgl2 done", 32'(done_cnt - d0), 32'd1);
    chk("tgl2 data", 32'(RxData), 32'hC3);
    chk("tgl2 ferr", 32'(FrameError), 32'd0);

    // Reset in the middle of data bit 4 aborts the frame
    OverSel = 1'b0;
    d0 = done_cnt;
    RxIn = 1'b0;
    wait_clk(bit_clks(1'b0));
    for (int i = 0; i < 4; i++) begin
      RxIn = i[0];
      wait_clk(bit_clks(1'b0));
    end
    RxIn = 1'b0;
    wait_clk(bit_clks(1'b0) / 2);
    chk("pre-rst busy", 32'(Busy), 32'd1);
    ResetN = 1'b0;
    #1;
    chk("abort data", 32'(RxData), 32'd0);
    chk("abort done", 32'(RxDone), 32'd0);
    chk("abort perr", 32'(ParityError), 32'd0);
    chk("abort ferr", 32'(FrameError), 32'd0);
    chk("abort busy", 32'(Busy), 32'd0);
    RxIn = 1'b1;
    wait_clk(4);
    ResetN = 1'b1;
    wait_clk(2 * bit_clks(1'b0));
    chk("abort no done", 32'(done_cnt - d0), 32'd0);
    run_vec('{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0}, "post-rst");

    chk("done width", 32'(max_run), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
